// File: rtl/lc3_mmio_pkg.sv
// Shared constants and types for the LC-3 memory-mapped I/O responder.
package lc3_mmio_pkg;
  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;
  localparam int RUN_BIT   = 15;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} dsp_state_t;
endpackage

// File: rtl/lc3_mmio_ctrl_if.sv
// Datapath-side MMIO bus: address/data/strobes out of the core, read data back.
interface lc3_mmio_ctrl_if;
  logic [15:0] mmio_addr;
  logic [15:0] mmio_wdata;
  logic        mmio_load;
  logic        mmio_rd;
  logic [15:0] mmio_rdata;

  modport master (output mmio_addr, mmio_wdata, mmio_load, mmio_rd, input mmio_rdata);
  modport slave  (input mmio_addr, mmio_wdata, mmio_load, mmio_rd, output mmio_rdata);
endinterface

// File: rtl/lc3_mmio_display.sv
// Display data register, byte handshake FSM and post-accept ready delay.
module lc3_mmio_display
  import lc3_mmio_pkg::*;
#(
  parameter int DSP_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ddr_wr_i,
  input  logic [7:0] ddr_wdata_i,
  input  logic       dsp_ready_i,
  output logic       dsp_valid_o,
  output logic [7:0] dsp_data_o,
  output logic       dsr_ready_o
);
  localparam int CW = $clog2(DSP_DELAY + 1);

  dsp_state_t  state_q;
  logic [7:0]  ddr_q;
  logic [CW-1:0] cnt_q;
  logic        valid_q;
  logic        rdy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ddr_q   <= 8'h00;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (ddr_wr_i) begin
          ddr_q   <= ddr_wdata_i;
          rdy_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (dsp_ready_i) begin
          // Counting down to zero inclusive gives DSP_DELAY edges to ready.
          cnt_q   <= CW'(DSP_DELAY - 1);
          valid_q <= 1'b0;
          state_q <= HOLD;
        end
        HOLD: if (cnt_q == '0) begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dsp_valid_o = valid_q;
  assign dsp_data_o  = ddr_q;
  assign dsr_ready_o = rdy_q;
endmodule

// File: rtl/lc3_mmio_ctrl.sv
// LC-3 MMIO responder: keyboard, display, MCR registers and interrupt request.
module lc3_mmio_ctrl
  import lc3_mmio_pkg::*;
#(
  parameter int         DSP_DELAY = 4,
  parameter logic [2:0] KB_PRIO   = 3'd4,
  parameter logic [2:0] DSP_PRIO  = 3'd4,
  parameter logic [7:0] KB_VEC    = 8'h80,
  parameter logic [7:0] DSP_VEC   = 8'h81
) (
  input  logic                  clk,
  input  logic                  rst,
  lc3_mmio_ctrl_if.slave        bus,
  input  logic                  kb_valid,
  input  logic [7:0]            kb_data,
  output logic                  kb_ready,
  output logic                  dsp_valid,
  output logic [7:0]            dsp_data,
  input  logic                  dsp_ready,
  output logic                  irq,
  output logic [2:0]            intp,
  output logic [7:0]            intv,
  output logic                  mcr_run
);
  logic       kbsr_rdy_q, kbsr_ie_q;
  logic [7:0] kbdr_q;
  logic       dsr_ie_q, mcr_run_q;
  logic       irq_q;
  logic [2:0] intp_q;
  logic [7:0] intv_q;
  logic       dsr_rdy;
  logic       kb_req, dsp_req;
  logic       unused_wdata;

  wire wr_kbsr = bus.mmio_load && bus.mmio_addr == ADDR_KBSR;
  wire wr_dsr  = bus.mmio_load && bus.mmio_addr == ADDR_DSR;
  wire wr_ddr  = bus.mmio_load && bus.mmio_addr == ADDR_DDR;
  wire wr_mcr  = bus.mmio_load && bus.mmio_addr == ADDR_MCR;
  wire rd_kbdr = bus.mmio_rd   && bus.mmio_addr == ADDR_KBDR;

  assign unused_wdata = ^bus.mmio_wdata[13:8];

  lc3_mmio_display #(.DSP_DELAY(DSP_DELAY)) u_dsp (
    .clk        (clk),
    .rst        (rst),
    .ddr_wr_i   (wr_ddr),
    .ddr_wdata_i(bus.mmio_wdata[7:0]),
    .dsp_ready_i(dsp_ready),
    .dsp_valid_o(dsp_valid),
    .dsp_data_o (dsp_data),
    .dsr_ready_o(dsr_rdy)
  );

  assign kb_ready = !kbsr_rdy_q;
  assign kb_req   = kbsr_rdy_q && kbsr_ie_q;
  assign dsp_req  = dsr_rdy && dsr_ie_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbsr_rdy_q <= 1'b0;
      kbsr_ie_q  <= 1'b0;
      kbdr_q     <= 8'h00;
      dsr_ie_q   <= 1'b0;
      mcr_run_q  <= 1'b1;
      irq_q      <= 1'b0;
      intp_q     <= 3'd0;
      intv_q     <= 8'h00;
    end else begin
      // Capture wins over the read-clear; they cannot collide since capture needs ready=0.
      if (kb_valid && kb_ready) begin
        kbdr_q     <= kb_data;
        kbsr_rdy_q <= 1'b1;
      end else if (rd_kbdr) begin
        kbsr_rdy_q <= 1'b0;
      end
      if (wr_kbsr) kbsr_ie_q <= bus.mmio_wdata[IE_BIT];
      if (wr_dsr)  dsr_ie_q  <= bus.mmio_wdata[IE_BIT];
      if (wr_mcr)  mcr_run_q <= bus.mmio_wdata[RUN_BIT];

      irq_q <= kb_req || dsp_req;
      if (kb_req) begin
        intp_q <= KB_PRIO;
        intv_q <= KB_VEC;
      end else if (dsp_req) begin
        intp_q <= DSP_PRIO;
        intv_q <= DSP_VEC;
      end else begin
        intp_q <= 3'd0;
        intv_q <= 8'h00;
      end
    end
  end

  always_comb begin
    bus.mmio_rdata = 16'h0000;
    if (bus.mmio_addr >= MMIO_BASE) begin
      case (bus.mmio_addr)
        ADDR_KBSR: begin
          bus.mmio_rdata[READY_BIT] = kbsr_rdy_q;
          bus.mmio_rdata[IE_BIT]    = kbsr_ie_q;
        end
        ADDR_KBDR: bus.mmio_rdata = {8'h00, kbdr_q};
        ADDR_DSR: begin
          bus.mmio_rdata[READY_BIT] = dsr_rdy;
          bus.mmio_rdata[IE_BIT]    = dsr_ie_q;
        end
        ADDR_MCR: bus.mmio_rdata[RUN_BIT] = mcr_run_q;
        default:  bus.mmio_rdata = 16'h0000;
      endcase
    end
  end

  assign irq     = irq_q;
  assign intp    = intp_q;
  assign intv    = intv_q;
  assign mcr_run = mcr_run_q;
endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// Directed bench for lc3_mmio_ctrl with hand-computed expectations.
module tb_lc3_mmio_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       kb_valid, kb_ready, dsp_valid, dsp_ready, irq, mcr_run;
  logic [7:0] kb_data, dsp_data, intv;
  logic [2:0] intp;
  int         n_chk = 0;
  int         n_pass = 0;

  lc3_mmio_ctrl_if bus();

  lc3_mmio_ctrl #(.DSP_DELAY(4)) dut (
    .clk(clk), .rst(rst_n), .bus(bus),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
    .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
    .irq(irq), .intp(intp), .intv(intv), .mcr_run(mcr_run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.mmio_addr = a; #1;
    chk(tag, {16'h0, bus.mmio_rdata}, {16'h0, exp});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.mmio_addr = a; bus.mmio_wdata = d; bus.mmio_load = 1'b1;
    step();
    bus.mmio_load = 1'b0;
  endtask

  // Read KBDR with the strobe asserted across one edge.
  task automatic rd_kbdr(input string tag, input logic [15:0] exp);
    bus.mmio_addr = 16'hFE02; bus.mmio_rd = 1'b1; #1;
    chk(tag, {16'h0, bus.mmio_rdata}, {16'h0, exp});
    step();
    bus.mmio_rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; kb_valid = 1'b0; kb_data = 8'h00; dsp_ready = 1'b0;
    bus.mmio_addr = 16'h0000; bus.mmio_wdata = 16'h0000;
    bus.mmio_load = 1'b0; bus.mmio_rd = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    rdchk("rst_dsr", 16'hFE04, 16'h8000);
    rdchk("rst_mcr", 16'hFFFE, 16'h8000);
    rdchk("rst_kbsr", 16'hFE00, 16'h0000);
    rdchk("rst_unmapped", 16'hFE10, 16'h0000);
    chk("rst_irq", irq, 1'b0);
    chk("rst_mcr_run", mcr_run, 1'b1);
    chk("rst_kb_ready", kb_ready, 1'b1);
    chk("rst_dsp_valid", dsp_valid, 1'b0);
    chk("rst_intv", intv, 8'h00);
    step();

    // Keyboard byte
    kb_valid = 1'b1; kb_data = 8'h41;
    step();
    kb_valid = 1'b0;
    rdchk("kb_kbsr_set", 16'hFE00, 16'h8000);
    chk("kb_ready_lo", kb_ready, 1'b0);
    rd_kbdr("kb_kbdr", 16'h0041);
    rdchk("kb_kbsr_clr", 16'hFE00, 16'h0000);
    chk("kb_ready_hi", kb_ready, 1'b1);

    // Read of KBDR colliding with a held kb_valid: capture deferred one cycle
    kb_valid = 1'b1; kb_data = 8'h42;
    step();
    kb_data = 8'h43;
    rd_kbdr("kb_coll_rd", 16'h0042);
    rdchk("kb_coll_kbsr", 16'hFE00, 16'h0000);
    rdchk("kb_coll_kbdr", 16'hFE02, 16'h0042);
    step();
    kb_valid = 1'b0;
    rdchk("kb_coll_cap", 16'hFE02, 16'h0043);
    rd_kbdr("kb_coll_clr", 16'h0043);

    // Display transfer with back-pressure, then ready delay
    wr(16'hFE06, 16'h0058);
    chk("dsp_valid_send", dsp_valid, 1'b1);
    chk("dsp_data_send", dsp_data, 8'h58);
    rdchk("dsp_dsr_busy", 16'hFE04, 16'h0000);
    rdchk("ddr_wo", 16'hFE06, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("dsp_hold_valid%0d", i), dsp_valid, 1'b1);
      chk($sformatf("dsp_hold_data%0d", i), dsp_data, 8'h58);
    end
    dsp_ready = 1'b1;
    step();
    dsp_ready = 1'b0;
    chk("dsp_valid_acc", dsp_valid, 1'b0);
    wr(16'hFE06, 16'h0059);
    rdchk("dsp_dly1", 16'hFE04, 16'h0000);
    step();
    rdchk("dsp_dly2", 16'hFE04, 16'h0000);
    step();
    rdchk("dsp_dly3", 16'hFE04, 16'h0000);
    step();
    rdchk("dsp_dly4", 16'hFE04, 16'h8000);
    chk("dsp_drop_data", dsp_data, 8'h58);
    chk("dsp_drop_valid", dsp_valid, 1'b0);

    // Keyboard interrupt
    wr(16'hFE00, 16'hFFFF);
    rdchk("kbsr_ie", 16'hFE00, 16'h4000);
    kb_valid = 1'b1; kb_data = 8'h55;
    step();
    kb_valid = 1'b0;
    chk("kirq_lat", irq, 1'b0);
    step();
    chk("kirq", irq, 1'b1);
    chk("kirq_intp", intp, 3'd4);
    chk("kirq_intv", intv, 8'h80);
    rd_kbdr("kirq_kbdr", 16'h0055);
    chk("kirq_hold", irq, 1'b1);
    step();
    chk("kirq_drop", irq, 1'b0);
    chk("kirq_intv0", intv, 8'h00);

    // Both sources: keyboard wins, then display
    wr(16'hFE04, 16'h4000);
    rdchk("dsr_ie", 16'hFE04, 16'hC000);
    kb_valid = 1'b1; kb_data = 8'h01;
    step();
    kb_valid = 1'b0;
    step();
    chk("both_irq", irq, 1'b1);
    chk("both_intv", intv, 8'h80);
    rd_kbdr("both_kbdr", 16'h0001);
    step();
    chk("dsp_intv", intv, 8'h81);
    chk("dsp_intp", intp, 3'd4);
    chk("dsp_irq", irq, 1'b1);

    // MCR and reset mid-transfer
    wr(16'hFFFE, 16'h0000);
    chk("mcr_halt", mcr_run, 1'b0);
    rdchk("mcr_rd0", 16'hFFFE, 16'h0000);
    wr(16'hFFFE, 16'hFFFF);
    rdchk("mcr_rd1", 16'hFFFE, 16'h8000);
    wr(16'hFFFE, 16'h0000);
    wr(16'hFE08, 16'hFFFF);
    rdchk("unmapped_wr", 16'hFE08, 16'h0000);
    wr(16'hFE06, 16'h0033);
    chk("rst_pre_valid", dsp_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk("arst_valid", dsp_valid, 1'b0);
    chk("arst_data", dsp_data, 8'h00);
    rdchk("arst_dsr", 16'hFE04, 16'h8000);
    chk("arst_mcr", mcr_run, 1'b1);
    chk("arst_irq", irq, 1'b0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", dsp_valid, 1'b0);
    chk("post_rst_intv", intv, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
